// File: rtl/dl_trans_sched.sv
// Downlink frequency-domain transmit scheduler: frame pulse, buffer read strobe/address,
// antenna slot index, and frame-aligned bandwidth configuration for the dual-carrier interleaver.
module dl_trans_sched #(
  parameter int          FRAME_LEN = 4096,
  parameter int          ADDR_W    = 12,
  parameter logic [3:0]  BW_RST    = 4'h4
) (
  input  logic              clk_491,
  input  logic              rst_491_n,
  input  logic              i_enable,
  input  logic              i_cfg_valid,
  input  logic [3:0]        i_cfg_bw,
  input  logic              i_err_clr,
  output logic              o_cfg_ack,
  output logic              o_cfg_err,
  output logic [31:0]       o_bandwidth_sel,
  output logic              o_freq_ffram,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [4:0]        o_ant_idx,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] FCNT_LAST = ADDR_W'(FRAME_LEN - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] fcnt, fcnt_n;
  logic [4:0]        acnt, acnt_n;
  logic [4:0]        ant_last;
  logic [3:0]        active_bw, active_n;
  logic [3:0]        pending_bw;
  logic              rd_en_q, busy_q, ffram_q, ack_q, err_q;
  logic              cfg_code_ok;

  function automatic logic bw_code_ok(input logic [3:0] code);
    case (code)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: bw_code_ok = 1'b1;
      default:                                              bw_code_ok = 1'b0;
    endcase
  endfunction

  assign cfg_code_ok = bw_code_ok(i_cfg_bw);

  // Antenna period is 32/16/8 slots; FRAME_LEN is a multiple of 32 so acnt is 0 at every wrap.
  always_comb begin
    case (active_bw)
      4'h1:       ant_last = 5'd31;
      4'h2, 4'h3: ant_last = 5'd15;
      default:    ant_last = 5'd7;
    endcase
  end

  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    acnt_n   = acnt;
    active_n = active_bw;
    case (state)
      ST_IDLE: begin
        if (i_enable) state_n = ST_ARM;
      end
      ST_ARM: begin
        active_n = pending_bw;
        fcnt_n   = '0;
        acnt_n   = '0;
        state_n  = ST_RUN;
      end
      ST_RUN: begin
        if (fcnt == FCNT_LAST) begin
          // Stop is only honoured here, so a frame is never truncated; counters hold on stop.
          if (!i_enable) begin
            state_n = ST_IDLE;
          end else begin
            fcnt_n   = '0;
            acnt_n   = '0;
            active_n = pending_bw;
          end
        end else begin
          fcnt_n = fcnt + 1'b1;
          acnt_n = (acnt == ant_last) ? 5'd0 : acnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_491 or negedge rst_491_n) begin
    if (!rst_491_n) begin
      state     <= ST_IDLE;
      fcnt      <= '0;
      acnt      <= '0;
      active_bw <= BW_RST;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      ffram_q   <= 1'b0;
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      acnt      <= acnt_n;
      active_bw <= active_n;
      rd_en_q   <= (state_n == ST_RUN);
      busy_q    <= (state_n != ST_IDLE);
      ffram_q   <= (state_n == ST_RUN) && (fcnt_n == '0);
    end
  end

  // Config handshake: i_cfg_valid is a one-cycle request with no back-pressure; it is always
  // accepted and answered by a one-cycle o_cfg_ack on the following cycle. Valid codes land in
  // pending_bw and only reach active_bw at ARM or a frame wrap.
  always_ff @(posedge clk_491 or negedge rst_491_n) begin
    if (!rst_491_n) begin
      pending_bw <= BW_RST;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q <= i_cfg_valid;
      if (i_cfg_valid && cfg_code_ok) pending_bw <= i_cfg_bw;
      if (i_cfg_valid && !cfg_code_ok) err_q <= 1'b1;
      else if (i_err_clr)              err_q <= 1'b0;
    end
  end

  assign o_cfg_ack       = ack_q;
  assign o_cfg_err       = err_q;
  assign o_bandwidth_sel = {28'd0, active_bw};
  assign o_freq_ffram    = ffram_q;
  assign o_rd_en         = rd_en_q;
  assign o_rd_addr       = fcnt;
  assign o_ant_idx       = acnt;
  assign o_busy          = busy_q;
  assign o_dbg_state     = state;

endmodule
